zero_one_event_counter: RTL

//  Downstream consumer of the 0->1 sequence detector's Y output.

---
 rtl/zero_one_event_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/zero_one_event_counter.sv
// zero_one_event_counter: counts pulses from the 0->1 sequence detector
// over windows of WINDOW clock edges. Each completed window total is
// offered on a valid/ready handshake, with a flag for saturation.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst          synchronous active-high reset; overrides every other input
//   Y            detector output; one event per edge where Y=1
//   en           run enable; starts a window from IDLE, aborts a window when low
//   count_ready  consumer accepts the held result
//   count        event total of the last delivered window
//   count_valid  result is held and waiting for acceptance (HOLD state)
//   ovf          last delivered result saturated
//   busy         window in progress (COUNT state)
module zero_one_event_counter #(
   parameter int unsigned WINDOW  = 8,
   parameter int unsigned COUNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               Y,
   input  logic               en,
   input  logic               count_ready,
   output logic [COUNT_W-1:0] count,
   output logic               count_valid,
   output logic               ovf,
   output logic               busy
);

   localparam int unsigned WIN_W = $clog2(WINDOW) + 1;
   localparam logic [WIN_W-1:0]   WIN_INIT = WIN_W'(WINDOW - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [COUNT_W-1:0] evt_q, evt_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               sat_q, sat_d;
   logic [COUNT_W-1:0] count_d;
   logic               ovf_d;

   // State register plus registered outputs, derived from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         evt_q       <= '0;
         win_q       <= '0;
         sat_q       <= 1'b0;
         count       <= '0;
         ovf         <= 1'b0;
         busy        <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         evt_q       <= evt_d;
         win_q       <= win_d;
         sat_q       <= sat_d;
         count       <= count_d;
         ovf         <= ovf_d;
         busy        <= (state_d == S_COUNT);
         count_valid <= (state_d == S_HOLD);
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      evt_d   = evt_q;
      win_d   = win_q;
      sat_d   = sat_q;
      count_d = count;
      ovf_d   = ovf;

      case (state_q)
         S_IDLE: begin
            // Entry edge starts a window; Y on this edge is not sampled
            if (en) begin
               state_d = S_COUNT;
               evt_d   = '0;
               win_d   = WIN_INIT;
               sat_d   = 1'b0;
            end
         end

         S_COUNT: begin
            if (!en) begin
               // Abort: partial total is dropped, delivered result untouched
               state_d = S_IDLE;
            end else begin
               if (Y) begin
                  if (evt_q == CNT_MAX) sat_d = 1'b1;
                  else                  evt_d = evt_q + COUNT_W'(1);
               end
               // Last sample of the window: publish including this edge's Y
               if (win_q == '0) begin
                  state_d = S_HOLD;
                  count_d = evt_d;
                  ovf_d   = sat_d;
               end else begin
                  win_d = win_q - WIN_W'(1);
               end
            end
         end

         S_HOLD: begin
            // Y and en are ignored until the consumer accepts
            if (count_ready) begin
               if (en) begin
                  state_d = S_COUNT;
                  evt_d   = '0;
                  win_d   = WIN_INIT;
                  sat_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
